// File: rtl/tetris_input_arbiter_pkg.sv
// Shared command codes, arbiter state type and priority helper for the Tetris input path.
package tetris_input_arbiter_pkg;

    localparam int CMD_W   = 3;
    localparam int NUM_SRC = 6;

    localparam logic [CMD_W-1:0] CMD_NONE    = 3'd0;
    localparam logic [CMD_W-1:0] CMD_GRAVITY = 3'd1;
    localparam logic [CMD_W-1:0] CMD_DROP    = 3'd2;
    localparam logic [CMD_W-1:0] CMD_ROTATE  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_LEFT    = 3'd4;
    localparam logic [CMD_W-1:0] CMD_RIGHT   = 3'd5;
    localparam logic [CMD_W-1:0] CMD_DOWN    = 3'd6;

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } arb_state_t;

    // Pending bit i carries command code i+1, so the lowest set bit is the highest priority.
    function automatic logic [CMD_W-1:0] first_pending(input logic [NUM_SRC-1:0] p);
        logic [CMD_W-1:0] c;
        c = CMD_NONE;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (p[i-1]) c = CMD_W'(i);
        end
        return c;
    endfunction

endpackage

// File: rtl/tetris_input_arbiter_key_repeat.sv
// Press-edge detector with optional hold-to-repeat timer for one debounced key.
module key_repeat #(
    parameter int unsigned REPEAT_DELAY = 6250000,
    parameter int unsigned REPEAT_RATE  = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic key,
    input  logic repeat_en,
    output logic evt
);

    logic        key_prev;
    logic        active;
    logic        phase;
    logic [31:0] cnt;
    logic        press;
    logic        hit;

    assign press = key & ~key_prev;
    // phase 0 waits for the initial delay, phase 1 for the steady repeat rate
    assign hit   = active & (phase ? (cnt == 32'(REPEAT_RATE - 1))
                                   : (cnt == 32'(REPEAT_DELAY - 1)));
    assign evt   = enable & (press | (repeat_en & key & hit));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_prev <= key;
            active   <= 1'b0;
            phase    <= 1'b0;
            cnt      <= '0;
        end else begin
            key_prev <= key;
            if (!enable || !repeat_en || !key) begin
                active <= 1'b0;
                phase  <= 1'b0;
                cnt    <= '0;
            end else if (press) begin
                active <= 1'b1;
                phase  <= 1'b0;
                cnt    <= '0;
            end else if (hit) begin
                phase  <= 1'b1;
                cnt    <= '0;
            end else if (active) begin
                cnt    <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/tetris_input_arbiter.sv
// Turns key levels and the gravity tick into prioritised, one-at-a-time game commands.
module tetris_input_arbiter
    import tetris_input_arbiter_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 6250000,
    parameter int unsigned REPEAT_RATE  = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_rotate,
    input  logic       key_down,
    input  logic       key_drop,
    input  logic       gravity_tick,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code
);

    logic [NUM_SRC-1:0] evts;
    logic [NUM_SRC-1:0] pending, pending_d;
    logic [NUM_SRC-1:0] grant;
    logic [CMD_W-1:0]   sel_code;
    logic [CMD_W-1:0]   code_d;
    arb_state_t         state, state_d;

    logic [NUM_SRC-1:1] key_lvl;
    logic [NUM_SRC-1:1] key_rep;

    assign evts[0] = gravity_tick;
    assign key_lvl = {key_down, key_right, key_left, key_rotate, key_drop};
    assign key_rep = 5'b11100;

    for (genvar g = 1; g < NUM_SRC; g++) begin : g_key
        key_repeat #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_key (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (enable),
            .key       (key_lvl[g]),
            .repeat_en (key_rep[g]),
            .evt       (evts[g])
        );
    end

    assign sel_code  = first_pending(pending);
    assign cmd_valid = (state == ST_OFFER);

    always_comb begin
        state_d = state;
        code_d  = cmd_code;
        grant   = '0;
        case (state)
            ST_IDLE: begin
                if (enable && (sel_code != CMD_NONE)) begin
                    for (int unsigned i = 0; i < NUM_SRC; i++) begin
                        grant[i] = (sel_code == CMD_W'(i + 1));
                    end
                    code_d  = sel_code;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (cmd_ready) begin
                    code_d  = CMD_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                code_d  = CMD_NONE;
                state_d = ST_IDLE;
            end
        endcase
        // OR-ing new events after the grant clear lets a same-edge event survive
        pending_d = enable ? ((pending & ~grant) | evts) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cmd_code <= CMD_NONE;
            pending  <= '0;
        end else begin
            state    <= state_d;
            cmd_code <= code_d;
            pending  <= pending_d;
        end
    end

endmodule

// File: tb/tb_tetris_input_arbiter.sv
// Randomised and directed scoreboard bench for tetris_input_arbiter with a held-duration model.
module tb_tetris_input_arbiter;

    localparam int D = 8;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst_n, enable;
    logic       key_left, key_right, key_rotate, key_down, key_drop;
    logic       gravity_tick, cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;

    int total = 0;
    int bad   = 0;
    int n_offers = 0;
    bit mon_en = 1'b0;

    int exp_q[$];

    // model state
    bit       m_pend[6];
    bit       m_prev[6];
    int       m_dur[6];
    bit       m_offer = 1'b0;

    always #5 clk = ~clk;

    tetris_input_arbiter #(
        .REPEAT_DELAY (D),
        .REPEAT_RATE  (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_rotate   (key_rotate),
        .key_down     (key_down),
        .key_drop     (key_drop),
        .gravity_tick (gravity_tick),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Sources indexed by command code minus one: gravity, drop, rotate, left, right, down.
    task automatic model_step();
        bit lvl[6];
        bit ev[6];
        int g;
        lvl[0] = 1'b0;
        lvl[1] = key_drop;
        lvl[2] = key_rotate;
        lvl[3] = key_left;
        lvl[4] = key_right;
        lvl[5] = key_down;
        if (!rst_n) begin
            m_offer = 1'b0;
            for (int i = 0; i < 6; i++) begin
                m_pend[i] = 1'b0;
                m_prev[i] = lvl[i];
                m_dur[i]  = -1;
            end
            return;
        end
        ev[0] = gravity_tick;
        for (int i = 1; i < 6; i++) begin
            ev[i] = 1'b0;
            if (lvl[i] && !m_prev[i]) begin
                ev[i] = 1'b1;
                m_dur[i] = 0;
            end else if (lvl[i] && m_dur[i] >= 0) begin
                m_dur[i]++;
                if (i >= 3 && (m_dur[i] == D || (m_dur[i] > D && (m_dur[i] - D) % R == 0)))
                    ev[i] = 1'b1;
            end else if (!lvl[i]) begin
                m_dur[i] = -1;
            end
            m_prev[i] = lvl[i];
            if (!enable) m_dur[i] = -1;
        end
        if (!m_offer) begin
            g = -1;
            if (enable)
                for (int i = 5; i >= 0; i--) if (m_pend[i]) g = i;
            if (g >= 0) begin
                m_pend[g] = 1'b0;
                m_offer = 1'b1;
                exp_q.push_back(g + 1);
            end
        end else if (cmd_ready) begin
            m_offer = 1'b0;
        end
        for (int i = 0; i < 6; i++) m_pend[i] = enable ? (m_pend[i] | ev[i]) : 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        if (!rst_n) mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin : monitor
        bit       last_valid;
        bit [2:0] last_code;
        int       e;
        last_valid = 1'b0;
        last_code  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                chk("valid", int'(cmd_valid), int'(m_offer));
                if (cmd_valid && !last_valid) begin
                    n_offers++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_cmd", int'(cmd_code), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_code", int'(cmd_code), e);
                    end
                end else if (cmd_valid) begin
                    chk("code_stable", int'(cmd_code), int'(last_code));
                end else begin
                    chk("idle_code", int'(cmd_code), 0);
                end
                last_valid = cmd_valid;
                last_code  = cmd_code;
            end
        end
    end

    initial begin : stim
        int n0;
        rst_n = 1'b0; enable = 1'b1; cmd_ready = 1'b1; gravity_tick = 1'b0;
        key_left = 1'b0; key_right = 1'b0; key_rotate = 1'b0; key_down = 1'b0; key_drop = 1'b0;
        @(negedge clk);
        idle(3);
        chk("reset_valid", int'(cmd_valid), 0);
        chk("reset_code", int'(cmd_code), 0);
        rst_n = 1'b1;
        idle(3);

        // single rotate press, latency check
        n0 = n_offers;
        key_rotate = 1'b1;
        tick();
        chk("lat_e0_valid", int'(cmd_valid), 0);
        tick();
        chk("lat_e1_valid", int'(cmd_valid), 1);
        chk("lat_e1_code", int'(cmd_code), 3);
        idle(18);
        key_rotate = 1'b0;
        idle(5);
        chk("rotate_count", n_offers - n0, 1);

        // left held 30 cycles: press, +8, +12, +16, +20, +24, +28
        n0 = n_offers;
        key_left = 1'b1;
        idle(30);
        key_left = 1'b0;
        idle(20);
        chk("left_repeat_count", n_offers - n0, 7);

        // gravity, drop and down together
        n0 = n_offers;
        gravity_tick = 1'b1; key_drop = 1'b1; key_down = 1'b1;
        tick();
        gravity_tick = 1'b0;
        idle(7);
        key_drop = 1'b0; key_down = 1'b0;
        idle(5);
        chk("trio_count", n_offers - n0, 3);

        // back-pressure with coalesced gravity
        n0 = n_offers;
        cmd_ready = 1'b0;
        key_rotate = 1'b1;
        idle(2);
        for (int i = 0; i < 10; i++) begin
            gravity_tick = (i == 2 || i == 5);
            tick();
        end
        gravity_tick = 1'b0;
        chk("hold_valid", int'(cmd_valid), 1);
        chk("hold_code", int'(cmd_code), 3);
        cmd_ready = 1'b1;
        key_rotate = 1'b0;
        idle(10);
        chk("coalesce_count", n_offers - n0, 2);

        // enable low flushes a pending LEFT
        n0 = n_offers;
        cmd_ready = 1'b0;
        key_rotate = 1'b1;
        idle(2);
        key_left = 1'b1;
        idle(2);
        enable = 1'b0;
        idle(3);
        chk("disabled_offer_held", int'(cmd_valid), 1);
        cmd_ready = 1'b1;
        idle(3);
        key_left = 1'b0; key_rotate = 1'b0;
        tick();
        enable = 1'b1;
        idle(10);
        chk("flush_count", n_offers - n0, 1);

        // key held across reset gives nothing
        n0 = n_offers;
        key_left = 1'b1;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(20);
        key_left = 1'b0;
        idle(5);
        chk("held_reset_count", n_offers - n0, 0);

        // reset in the middle of an offer
        n0 = n_offers;
        cmd_ready = 1'b0;
        key_rotate = 1'b1;
        idle(2);
        chk("pre_reset_valid", int'(cmd_valid), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_reset_valid", int'(cmd_valid), 0);
        chk("mid_reset_code", int'(cmd_code), 0);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        idle(10);
        key_rotate = 1'b0;
        idle(5);
        chk("reset_offer_count", n_offers - n0, 1);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(11) == 0) key_left   = ~key_left;
            if ($urandom_range(11) == 0) key_right  = ~key_right;
            if ($urandom_range(15) == 0) key_rotate = ~key_rotate;
            if ($urandom_range(13) == 0) key_down   = ~key_down;
            if ($urandom_range(19) == 0) key_drop   = ~key_drop;
            gravity_tick = ($urandom_range(19) == 0);
            cmd_ready    = ($urandom_range(9) < 7);
            enable       = ($urandom_range(99) != 0);
            tick();
        end
        key_left = 1'b0; key_right = 1'b0; key_rotate = 1'b0; key_down = 1'b0; key_drop = 1'b0;
        gravity_tick = 1'b0; cmd_ready = 1'b1; enable = 1'b1;
        idle(30);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
